dispatch_stage: RTL

- Registered decode/dispatch stage between the fetcher and the ROB, RS and LSB.
- Accepts one instruction per cycle from the fetcher using a valid/ready handshake. Resolves source operands from the register file, the ROB and N_CDB broadcast channels, and holds the instruction in a one-entry issue register until the ROB and the target queue can take it.
- While held, the entry keeps snooping the CDB so that waiting operands wake up. Flush and backpressure are supported.

---
 rtl/dispatch_stage.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dispatch_stage.sv
// Decode/dispatch stage: resolves operands at accept, holds one instruction in an
// issue register that snoops the CDB, and hands it to the ROB and the RS or LSB.

module dispatch_opnd #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int N_CDB  = 2
) (
    input  logic [4:0]              rs,
    input  logic                    used,
    input  logic                    fwd_en,
    input  logic [4:0]              fwd_dest,
    input  logic [ROB_W-1:0]        freetag,
    input  logic [DATA_W-1:0]       reg_value,
    input  logic [ROB_W-1:0]        reg_robtag,
    input  logic                    reg_busy,
    input  logic [DATA_W-1:0]       rob_value,
    input  logic                    rob_ready,
    input  logic [N_CDB-1:0]        cdb_valid,
    input  logic [N_CDB*ROB_W-1:0]  cdb_tag,
    input  logic [N_CDB*DATA_W-1:0] cdb_value,
    input  logic [DATA_W-1:0]       held_value,
    input  logic [ROB_W-1:0]        held_tag,
    output logic [DATA_W-1:0]       cap_value,
    output logic [ROB_W-1:0]        cap_tag,
    output logic [DATA_W-1:0]       wake_value,
    output logic [ROB_W-1:0]        wake_tag
);
    logic              hit_c, hit_w;
    logic [DATA_W-1:0] val_c, val_w;

    // Scan from the top channel down so the lowest matching channel wins.
    always_comb begin
        hit_c = 1'b0;
        hit_w = 1'b0;
        val_c = '0;
        val_w = '0;
        for (int i = N_CDB - 1; i >= 0; i--) begin
            if (cdb_valid[i] && cdb_tag[i*ROB_W +: ROB_W] == reg_robtag) begin
                hit_c = 1'b1;
                val_c = cdb_value[i*DATA_W +: DATA_W];
            end
            if (cdb_valid[i] && cdb_tag[i*ROB_W +: ROB_W] == held_tag) begin
                hit_w = 1'b1;
                val_w = cdb_value[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        cap_value = '0;
        cap_tag   = '0;
        if (!used || rs == 5'd0) begin
            cap_value = '0;
        end else if (fwd_en && fwd_dest == rs) begin
            cap_tag = freetag;
        end else if (!reg_busy) begin
            cap_value = reg_value;
        end else if (rob_ready) begin
            cap_value = rob_value;
        end else if (hit_c) begin
            cap_value = val_c;
        end else begin
            cap_tag = reg_robtag;
        end
    end

    always_comb begin
        wake_value = held_value;
        wake_tag   = held_tag;
        if (held_tag != '0 && hit_w) begin
            wake_value = val_w;
            wake_tag   = '0;
        end
    end
endmodule

module dispatch_stage #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int N_CDB  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    in_fetcher_valid,
    input  logic [31:0]             in_fetcher_inst,
    input  logic [DATA_W-1:0]       in_fetcher_pc,
    input  logic                    in_fetcher_jump_flag,
    output logic                    out_fetcher_ready,
    input  logic [OP_W-1:0]         in_dcd_openum,
    input  logic [DATA_W-1:0]       in_dcd_imm,
    output logic [4:0]              out_reg_tag1,
    output logic [4:0]              out_reg_tag2,
    input  logic [DATA_W-1:0]       in_reg_value1,
    input  logic [DATA_W-1:0]       in_reg_value2,
    input  logic [ROB_W-1:0]        in_reg_robtag1,
    input  logic [ROB_W-1:0]        in_reg_robtag2,
    input  logic                    in_reg_busy1,
    input  logic                    in_reg_busy2,
    output logic [ROB_W-1:0]        out_rob_fetch_tag1,
    output logic [ROB_W-1:0]        out_rob_fetch_tag2,
    input  logic [DATA_W-1:0]       in_rob_fetch_value1,
    input  logic [DATA_W-1:0]       in_rob_fetch_value2,
    input  logic                    in_rob_fetch_ready1,
    input  logic                    in_rob_fetch_ready2,
    input  logic                    in_rob_full,
    input  logic [ROB_W-1:0]        in_rob_freetag,
    input  logic                    in_rs_full,
    input  logic                    in_lsb_full,
    input  logic [N_CDB-1:0]        in_cdb_valid,
    input  logic [N_CDB*ROB_W-1:0]  in_cdb_tag,
    input  logic [N_CDB*DATA_W-1:0] in_cdb_value,
    input  logic                    in_flush,
    output logic                    out_rob_valid,
    output logic                    out_rs_valid,
    output logic                    out_lsb_valid,
    output logic                    out_reg_valid,
    output logic [ROB_W-1:0]        out_rob_tag,
    output logic [OP_W-1:0]         out_rob_op,
    output logic [4:0]              out_rob_dest,
    output logic                    out_rob_jump_flag,
    output logic [DATA_W-1:0]       out_pc,
    output logic [OP_W-1:0]         out_op,
    output logic [DATA_W-1:0]       out_value1,
    output logic [DATA_W-1:0]       out_value2,
    output logic [ROB_W-1:0]        out_tag1,
    output logic [ROB_W-1:0]        out_tag2,
    output logic [DATA_W-1:0]       out_imm,
    output logic [4:0]              out_reg_dest
);
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [OP_W-1:0]   op;
        logic [4:0]        dest;
        logic              jump;
        logic              lsb;
        logic [DATA_W-1:0] imm;
    } held_t;

    logic                   hold_valid;
    held_t                  held;
    logic [1:0][DATA_W-1:0] h_val, cap_val, wake_val;
    logic [1:0][ROB_W-1:0]  h_tag, cap_tag, wake_tag;

    logic [6:0]             opc;
    logic                   legal, is_lsb, no_dest;
    logic [1:0]             used;
    logic [1:0][4:0]        rs_idx;
    logic [1:0][DATA_W-1:0] reg_val, rob_val;
    logic [1:0][ROB_W-1:0]  reg_tag;
    logic [1:0]             reg_busy, rob_rdy;
    logic                   fire, accept, q_full;
    logic                   unused_inst;

    assign opc         = in_fetcher_inst[6:0];
    assign rs_idx      = {in_fetcher_inst[24:20], in_fetcher_inst[19:15]};
    assign unused_inst = ^{in_fetcher_inst[31:25], in_fetcher_inst[14:12]};

    always_comb begin
        legal   = 1'b1;
        is_lsb  = 1'b0;
        no_dest = 1'b0;
        used    = 2'b00;
        case (opc)
            7'b0110111, 7'b0010111, 7'b1101111: used = 2'b00;
            7'b1100111, 7'b0010011:             used = 2'b01;
            7'b0110011:                         used = 2'b11;
            7'b1100011: begin used = 2'b11; no_dest = 1'b1; end
            7'b0000011: begin used = 2'b01; is_lsb = 1'b1; end
            7'b0100011: begin used = 2'b11; is_lsb = 1'b1; no_dest = 1'b1; end
            default:    legal = 1'b0;
        endcase
    end

    assign q_full            = held.lsb ? in_lsb_full : in_rs_full;
    assign fire              = hold_valid & ~in_rob_full & ~q_full & ~in_flush & rdy;
    assign out_fetcher_ready = rdy & rst & ~in_flush & (~hold_valid | fire);
    assign accept            = in_fetcher_valid & out_fetcher_ready;

    assign reg_val  = {in_reg_value2, in_reg_value1};
    assign reg_tag  = {in_reg_robtag2, in_reg_robtag1};
    assign reg_busy = {in_reg_busy2, in_reg_busy1};
    assign rob_val  = {in_rob_fetch_value2, in_rob_fetch_value1};
    assign rob_rdy  = {in_rob_fetch_ready2, in_rob_fetch_ready1};

    for (genvar g = 0; g < 2; g++) begin : g_opnd
        dispatch_opnd #(.DATA_W(DATA_W), .ROB_W(ROB_W), .N_CDB(N_CDB)) u_opnd (
            .rs         (rs_idx[g]),
            .used       (used[g]),
            .fwd_en     (fire),
            .fwd_dest   (held.dest),
            .freetag    (in_rob_freetag),
            .reg_value  (reg_val[g]),
            .reg_robtag (reg_tag[g]),
            .reg_busy   (reg_busy[g]),
            .rob_value  (rob_val[g]),
            .rob_ready  (rob_rdy[g]),
            .cdb_valid  (in_cdb_valid),
            .cdb_tag    (in_cdb_tag),
            .cdb_value  (in_cdb_value),
            .held_value (h_val[g]),
            .held_tag   (h_tag[g]),
            .cap_value  (cap_val[g]),
            .cap_tag    (cap_tag[g]),
            .wake_value (wake_val[g]),
            .wake_tag   (wake_tag[g])
        );
    end

    // Illegal opcodes are consumed but leave the issue register empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            held       <= '0;
            h_val      <= '0;
            h_tag      <= '0;
        end else if (rdy) begin
            if (in_flush) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= legal;
                held.pc    <= in_fetcher_pc;
                held.op    <= in_dcd_openum;
                held.dest  <= no_dest ? 5'd0 : in_fetcher_inst[11:7];
                held.jump  <= in_fetcher_jump_flag;
                held.lsb   <= is_lsb;
                held.imm   <= in_dcd_imm;
                h_val      <= cap_val;
                h_tag      <= cap_tag;
            end else begin
                if (fire) hold_valid <= 1'b0;
                if (hold_valid) begin
                    h_val <= wake_val;
                    h_tag <= wake_tag;
                end
            end
        end
    end

    assign out_reg_tag1       = rs_idx[0];
    assign out_reg_tag2       = rs_idx[1];
    assign out_rob_fetch_tag1 = in_reg_robtag1;
    assign out_rob_fetch_tag2 = in_reg_robtag2;

    assign out_rob_valid     = fire;
    assign out_rs_valid      = fire & ~held.lsb;
    assign out_lsb_valid     = fire & held.lsb;
    assign out_reg_valid     = fire & (held.dest != 5'd0);
    assign out_rob_tag       = in_rob_freetag;
    assign out_rob_op        = held.op;
    assign out_rob_dest      = held.dest;
    assign out_rob_jump_flag = held.jump;
    assign out_pc            = held.pc;
    assign out_op            = held.op;
    assign out_imm           = held.imm;
    assign out_reg_dest      = held.dest;
    // Same-cycle CDB wakeups are forwarded so the consumer never sees a stale tag.
    assign out_value1        = wake_val[0];
    assign out_value2        = wake_val[1];
    assign out_tag1          = wake_tag[0];
    assign out_tag2          = wake_tag[1];
endmodule
